uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmit write port (`w_data`/`wr_uart`/`tx_full`) between `NREQ` byte-stream requesters. A grant is held for a whole packet, which ends on the requester's `last` flag, or until a burst limit is reached, so bytes from different requesters do not interleave within a packet. Sits between on-chip producers (command responder, debug printer, status reporter) and the `uart` top's TX FIFO.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DBIT`, 8: data byte width; must match the UART `w_data` width.
- `MAX_BURST`, 16: bytes accepted per grant before a forced release. 0 = unlimited.
- `clk` input 1: single system clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input NREQ: requester i has a byte valid on its data slice.
- `req_data` input NREQ*DBIT: byte of requester i at bits [i*DBIT +: DBIT].
- `req_last` input NREQ: the byte of requester i is the final byte of its packet.
- `ack` output NREQ: one-hot. Byte of requester i is written to the FIFO this cycle.
- `grant` output NREQ: one-hot registered current owner. All zero when idle.
- `busy` output 1: a grant is held.
- `tx_full` input 1: UART TX FIFO full.
- `wr_uart` output 1: TX FIFO write strobe.
- `w_data` output DBIT: byte to the TX FIFO.

## Operation
- The FSM has two states, IDLE and HOLD. The registered state holds `gidx` (owner index), `rr_ptr` (last owner) and `bcnt` (bytes in the current grant, width clog2(MAX_BURST+1), minimum 1).
- IDLE:
  - If `req` is nonzero, select the first set bit scanning from `rr_ptr+1` mod NREQ upward with wrap.
  - Load `gidx`, set `grant`, clear `bcnt`, and go to HOLD.
  - No write ever occurs in IDLE.
- HOLD, all combinational:
  - `wr_uart` = `req[gidx]` & ~`tx_full`.
  - `w_data` = the `req_data` slice of `gidx`.
  - `ack[gidx]` = `wr_uart`.
  - When `wr_uart` is 0, `w_data` is still the owner's slice and is don't-care.
- HOLD transitions, on an accepted byte (`wr_uart`=1):
  - `bcnt` increments.
  - If `req_last[gidx]`=1, the grant releases.
  - Else, if MAX_BURST≠0 and `bcnt`+1 = MAX_BURST, the grant is force-released. The packet is then continued in a later grant and may be interleaved with other requesters. Producers that need atomic packets keep them ≤ MAX_BURST bytes.
- HOLD transition when `req[gidx]`=0 (owner withdraws): release with no write.
- Release action: next state IDLE, `rr_ptr` ← `gidx`, `grant` ← 0.
- `tx_full`=1 stalls the owner. The grant is kept, `bcnt` is unchanged, there is no timeout, and other requesters wait.
- Requesters keep `req`, `req_data` and `req_last` stable until `ack`. A non-owner's `req` is never acked.
- Reset:
  - State IDLE, `grant`=0, `busy`=0, `bcnt`=0.
  - `rr_ptr`=NREQ-1, so requester 0 wins first.
  - Combinationally `wr_uart`=0, `ack`=0 and `w_data`=0 (the slice of `gidx`=0 is not driven out while IDLE; `w_data` is forced 0 in IDLE).
- Reset asserted mid-packet: the grant is dropped on the next edge, with no partial-byte effect. The byte being written in that cycle is still written, because `wr_uart` is combinational that cycle.

## Timing
- Arbitration latency: if `req` is first seen in IDLE at edge t, `grant`/`busy` are set after t. The first `wr_uart` can occur in the cycle following edge t, i.e. one idle cycle after the request.
- Throughput within a grant: one byte per cycle while `req` is held and `tx_full`=0.
- Packet-to-packet gap: exactly one IDLE cycle after the last byte before the next owner's first write, including when the same requester requests again.
- Simultaneous requests: resolved purely by round-robin from `rr_ptr`. No requester waits more than NREQ-1 grants.
- `req_last` and the burst limit reached on the same byte: a single release, `rr_ptr` ← `gidx`.
- `tx_full` rising in the same cycle as `req`: no write that cycle, and the write retries every cycle until `tx_full`=0.

## Test plan
- **Reset:** hold `rst` 2 cycles with all `req`=1.
  - During reset: `grant`=0, `wr_uart`=0, `ack`=0.
  - After release: `grant`=0001 one cycle later, then 0001 is written first.
- **Round-robin:** `req`=1111, each requester sends a 3-byte packet with `last` on the 3rd byte.
  - Grant order is 0,1,2,3,0.
  - Exactly one idle cycle between packets.
  - `w_data` sequence matches each requester's bytes with no interleave.
- **Back-pressure:** requester 2 holds a 4-byte packet and `tx_full`=1 for 5 cycles mid-packet.
  - No `wr_uart` and no `ack` while `tx_full`=1.
  - `grant` stays 0100.
  - The remaining bytes follow on consecutive cycles once `tx_full` clears.
- **Burst limit:** MAX_BURST=16, requester 1 sends a 20-byte packet and requester 3 also requests.
  - Grant releases after byte 16, requester 3 is served, then requester 1 sends bytes 17–20.
- **Withdraw:** the owner drops `req` without `last` after 2 bytes.
  - Release next edge, `rr_ptr` advances, and the next requester is granted.
- **Reset mid-packet:** `rst` asserted during byte 3 of 5.
  - `busy`=0 the next cycle.
  - Arbitration restarts with requester 0 priority.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
// Bundle between NREQ byte-stream requesters, the round-robin arbiter and
// the UART TX FIFO write port.
//   req       : requester i has a byte valid on its slice of req_data
//   req_data  : byte of requester i at bits [i*DBIT +: DBIT]
//   req_last  : byte of requester i ends its packet
//   ack       : one-hot, byte of requester i is written this cycle
//   grant     : one-hot registered owner, zero when idle
//   busy      : a grant is held
//   tx_full   : UART TX FIFO full
//   wr_uart   : TX FIFO write strobe
//   w_data    : byte to the TX FIFO
// The slave modport is the arbiter. The master modport is the producer/FIFO side.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DBIT = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*DBIT-1:0] req_data;
    logic [NREQ-1:0]      req_last;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      grant;
    logic                 busy;
    logic                 tx_full;
    logic                 wr_uart;
    logic [DBIT-1:0]      w_data;

    modport master (
        output req, req_data, req_last, tx_full,
        input  ack, grant, busy, wr_uart, w_data
    );

    modport slave (
        input  req, req_data, req_last, tx_full,
        output ack, grant, busy, wr_uart, w_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares the single UART TX FIFO write port between NREQ byte-stream
// requesters. The owner is chosen round-robin and keeps the port for a whole
// packet (until its req_last byte), until it withdraws, or until MAX_BURST
// bytes have been accepted (MAX_BURST = 0 means no limit).
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_tx_arbiter_if slave modport (requests, acks, FIFO write port)
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int DBIT      = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_tx_arbiter_if.slave      bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [BW-1:0] BURST_END = BW'((MAX_BURST > 0) ? MAX_BURST : 0);
    localparam logic [NREQ-1:0] ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     gidx_q, gidx_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]     bcnt_q, bcnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic              busy_q, busy_d;

    logic              pick_found_s;
    logic [IW-1:0]     pick_idx_s;
    logic              wr_s;
    logic [NREQ-1:0]   ack_s;
    logic [DBIT-1:0]   wdata_s;
    logic              burst_hit_s;

    // Round-robin pick: first requesting index after rr_ptr, wrapping.
    always_comb begin : rr_pick
        logic [IW-1:0] cand;
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        cand         = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(rr_ptr_q) + k) % NREQ);
            if (!pick_found_s && bus.req[cand]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = cand;
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Owner's write path; nothing is written and w_data is forced to zero in IDLE.
    always_comb begin
        wr_s    = 1'b0;
        ack_s   = '0;
        wdata_s = '0;
        if (state_q == HOLD) begin
            wr_s          = bus.req[gidx_q] & ~bus.tx_full;
            wdata_s       = bus.req_data[int'(gidx_q)*DBIT +: DBIT];
            ack_s[gidx_q] = wr_s;
        end else begin
            wr_s = 1'b0;
        end
    end

    // The byte accepted now is the last one this grant may carry.
    always_comb begin
        burst_hit_s = (MAX_BURST != 0) && ((bcnt_q + BW'(1)) == BURST_END);
    end

    // Next-state logic for the IDLE/HOLD grant FSM.
    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        rr_ptr_d = rr_ptr_q;
        bcnt_d   = bcnt_q;
        grant_d  = grant_q;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_found_s) begin
                    state_d = HOLD;
                    gidx_d  = pick_idx_s;
                    grant_d = ONE_HOT0 << pick_idx_s;
                    busy_d  = 1'b1;
                    bcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                if (!bus.req[gidx_q]) begin
                    // Owner withdrew: release without a write.
                    state_d  = IDLE;
                    rr_ptr_d = gidx_q;
                    grant_d  = '0;
                    busy_d   = 1'b0;
                end else if (wr_s) begin
                    bcnt_d = bcnt_q + BW'(1);
                    // req_last and burst limit together still give a single release.
                    if (bus.req_last[gidx_q] || burst_hit_s) begin
                        state_d  = IDLE;
                        rr_ptr_d = gidx_q;
                        grant_d  = '0;
                        busy_d   = 1'b0;
                    end else begin
                        state_d = HOLD;
                    end
                end else begin
                    // Stalled by tx_full: keep the grant and the count.
                    state_d = HOLD;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; rr_ptr resets to NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gidx_q   <= '0;
            rr_ptr_q <= IW'(NREQ - 1);
            bcnt_q   <= '0;
            grant_q  <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            gidx_q   <= gidx_d;
            rr_ptr_q <= rr_ptr_d;
            bcnt_q   <= bcnt_d;
            grant_q  <= grant_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.wr_uart = wr_s;
    assign bus.ack     = ack_s;
    assign bus.w_data  = wdata_s;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter (NREQ=4, DBIT=8, MAX_BURST=16).
// Byte n of requester i carries (i+1)*16 + n, so every expected w_data value
// below is written out by hand.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int DBIT = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NREQ(NREQ), .DBIT(DBIT)) bus ();

    uart_tx_arbiter #(.NREQ(NREQ), .DBIT(DBIT), .MAX_BURST(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_assert = 0;
    int n_fail   = 0;
    bit active [NREQ];
    int bidx   [NREQ];
    int plen   [NREQ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producers present their current byte while active.
    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req[i]                   = active[i];
            bus.req_data[i*DBIT +: DBIT] = 8'((i + 1) * 16 + bidx[i]);
            bus.req_last[i]              = active[i] && (bidx[i] == plen[i] - 1);
        end
    endtask

    // One clock cycle: drive, check mid-cycle, let producers react to ack, advance.
    task automatic cyc(input string tag, input logic full, input logic [3:0] eg,
                       input logic ew, input logic [7:0] ed);
        bus.tx_full = full;
        drive();
        #1;
        check({tag, ".grant"}, 32'(bus.grant), 32'(eg));
        check({tag, ".busy"}, 32'(bus.busy), 32'(|eg));
        check({tag, ".wr_uart"}, 32'(bus.wr_uart), 32'(ew));
        check({tag, ".ack"}, 32'(bus.ack), 32'(ew ? eg : 4'b0000));
        if (ew || (eg == 4'b0000))
            check({tag, ".w_data"}, 32'(bus.w_data), 32'(ew ? ed : 8'h00));
        for (int i = 0; i < NREQ; i++) begin
            if (bus.ack[i]) begin
                if (bus.req_last[i]) begin
                    active[i] = 1'b0;
                    bidx[i]   = 0;
                end else begin
                    bidx[i] = bidx[i] + 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        rst = 1'b1;
        bus.tx_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            active[i] = 1'b1;
            bidx[i]   = 0;
            plen[i]   = 3;
        end
        drive();
        @(posedge clk);
        #1;

        // Reset held two cycles with every requester asking.
        cyc("rst0", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("rst1", 1'b0, 4'b0000, 1'b0, 8'h00);
        rst = 1'b0;
        cyc("rst_idle", 1'b0, 4'b0000, 1'b0, 8'h00);

        // Round robin 0,1,2,3,0 with 3-byte packets and one idle cycle between.
        for (int p = 0; p < 5; p++) begin
            for (int b = 0; b < 3; b++)
                cyc("rr", 1'b0, 4'(1 << order[p]), 1'b1, 8'((order[p] + 1) * 16 + b));
            if (p == 0)
                active[0] = 1'b1;
            cyc("rr_gap", 1'b0, 4'b0000, 1'b0, 8'h00);
        end

        // Back-pressure on requester 2; requester 0 waits meanwhile.
        active[2] = 1'b1; plen[2] = 4;
        active[0] = 1'b1; plen[0] = 1;
        cyc("bp_arb", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("bp", 1'b0, 4'b0100, 1'b1, 8'h30);
        cyc("bp", 1'b0, 4'b0100, 1'b1, 8'h31);
        for (int s = 0; s < 5; s++)
            cyc("bp_stall", 1'b1, 4'b0100, 1'b0, 8'h00);
        cyc("bp", 1'b0, 4'b0100, 1'b1, 8'h32);
        cyc("bp", 1'b0, 4'b0100, 1'b1, 8'h33);
        cyc("bp_gap", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("bp_next", 1'b0, 4'b0001, 1'b1, 8'h10);
        cyc("bp_gap2", 1'b0, 4'b0000, 1'b0, 8'h00);

        // Burst limit: 20-byte packet from requester 1, requester 3 cuts in after 16.
        active[1] = 1'b1; plen[1] = 20;
        active[3] = 1'b1; plen[3] = 2;
        cyc("burst_arb", 1'b0, 4'b0000, 1'b0, 8'h00);
        for (int b = 0; b < 16; b++)
            cyc("burst", 1'b0, 4'b0010, 1'b1, 8'(8'h20 + b));
        cyc("burst_rel", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("burst_r3", 1'b0, 4'b1000, 1'b1, 8'h40);
        cyc("burst_r3", 1'b0, 4'b1000, 1'b1, 8'h41);
        cyc("burst_gap", 1'b0, 4'b0000, 1'b0, 8'h00);
        for (int b = 16; b < 20; b++)
            cyc("burst_tail", 1'b0, 4'b0010, 1'b1, 8'(8'h20 + b));
        cyc("burst_gap2", 1'b0, 4'b0000, 1'b0, 8'h00);

        // Withdraw: requester 2 drops req after 2 bytes, requester 3 is next.
        active[2] = 1'b1; plen[2] = 5;
        active[3] = 1'b1; plen[3] = 1;
        cyc("wd_arb", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("wd", 1'b0, 4'b0100, 1'b1, 8'h30);
        cyc("wd", 1'b0, 4'b0100, 1'b1, 8'h31);
        active[2] = 1'b0; bidx[2] = 0;
        cyc("wd_rel", 1'b0, 4'b0100, 1'b0, 8'h00);
        cyc("wd_gap", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("wd_next", 1'b0, 4'b1000, 1'b1, 8'h40);
        cyc("wd_gap2", 1'b0, 4'b0000, 1'b0, 8'h00);

        // Reset during byte 3 of 5 from requester 2; afterwards requester 0 wins.
        active[2] = 1'b1; plen[2] = 5;
        cyc("rm_arb", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("rm", 1'b0, 4'b0100, 1'b1, 8'h30);
        cyc("rm", 1'b0, 4'b0100, 1'b1, 8'h31);
        rst = 1'b1;
        cyc("rm_byte3", 1'b0, 4'b0100, 1'b1, 8'h32);
        rst = 1'b0;
        active[0] = 1'b1; plen[0] = 1;
        cyc("rm_after", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("rm_r0", 1'b0, 4'b0001, 1'b1, 8'h10);
        cyc("rm_gap", 1'b0, 4'b0000, 1'b0, 8'h00);
        cyc("rm_r2", 1'b0, 4'b0100, 1'b1, 8'h33);
        cyc("rm_r2", 1'b0, 4'b0100, 1'b1, 8'h34);
        cyc("rm_end", 1'b0, 4'b0000, 1'b0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
